fetch_stage: RTL and testbench

//  Instruction-fetch stage that sits directly downstream of the PC register.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one imem request at a time, computes the next PC,
// and captures responses into the IF/ID register through a one-entry skid buffer.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [DATA_WIDTH-1:0] pc_next_o,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_target_i,
  input  logic                  stall_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic [DATA_WIDTH-1:0] instr_pcplus4_o,
  output logic                  instr_valid_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pending_pc;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  ifid_ready;
  logic                  granted;
  logic                  load_resp;
  logic                  load_skid;
  logic                  store_skid;

  assign ifid_ready = !instr_valid_o || !stall_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A redirect in DRAIN before the stale response arrives keeps draining, so a
  // late response can never be mistaken for the first post-redirect fetch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = REQ;
      REQ: begin
        if (redirect_i)      state_next = imem_gnt_i ? DRAIN : REQ;
        else if (imem_gnt_i) state_next = WAIT;
      end
      WAIT: begin
        if (redirect_i)         state_next = imem_rvalid_i ? REQ : DRAIN;
        else if (imem_rvalid_i) state_next = ifid_ready ? REQ : HOLD;
      end
      HOLD:  if (redirect_i || !stall_i) state_next = REQ;
      DRAIN: if (imem_rvalid_i) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = (state == REQ);
    imem_addr_o = pc_i;
    granted     = (state == REQ) && imem_gnt_i;
    load_resp   = (state == WAIT) && imem_rvalid_i && ifid_ready && !redirect_i;
    store_skid  = (state == WAIT) && imem_rvalid_i && !ifid_ready && !redirect_i;
    load_skid   = (state == HOLD) && !stall_i && !redirect_i;
    if (redirect_i)   pc_next_o = redirect_target_i;
    else if (granted) pc_next_o = pc_i + DATA_WIDTH'(4);
    else              pc_next_o = pc_i;
  end

  // IF/ID register and skid buffer; a redirect flushes both and overrides stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_pc      <= '0;
      skid_valid      <= 1'b0;
      skid_data       <= NOP_INSTR;
      instr_valid_o   <= 1'b0;
      instr_o         <= NOP_INSTR;
      instr_pc_o      <= '0;
      instr_pcplus4_o <= '0;
    end else begin
      if (granted) pending_pc <= pc_i;
      if (redirect_i) begin
        instr_valid_o <= 1'b0;
        instr_o       <= NOP_INSTR;
        skid_valid    <= 1'b0;
      end else begin
        if (store_skid) begin
          skid_valid <= 1'b1;
          skid_data  <= imem_rdata_i;
        end else if (load_skid) begin
          skid_valid <= 1'b0;
        end
        if (load_resp || load_skid) begin
          instr_o         <= load_resp ? imem_rdata_i : skid_data;
          instr_pc_o      <= pending_pc;
          instr_pcplus4_o <= pending_pc + DATA_WIDTH'(4);
          instr_valid_o   <= 1'b1;
        end else if (!stall_i) begin
          instr_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC register and instruction memory models, a transaction-level
// reference checked every cycle, and directed scenarios with hand-computed expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] target;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic [31:0] instrPc4;
  logic        instrValid;

  int checks = 0;
  int errors = 0;
  int memLat = 1;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc),
    .pc_next_o         (pcNext),
    .imem_req_o        (req),
    .imem_addr_o       (addr),
    .imem_gnt_i        (gnt),
    .imem_rvalid_i     (rvalid),
    .imem_rdata_i      (rdata),
    .redirect_i        (redirect),
    .redirect_target_i (target),
    .stall_i           (stall),
    .instr_o           (instr),
    .instr_pc_o        (instrPc),
    .instr_pcplus4_o   (instrPc4),
    .instr_valid_o     (instrValid)
  );

  function automatic logic [31:0] rdataOf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic rd, input logic [31:0] t, input logic g);
    stall    = s;
    redirect = rd;
    target   = t;
    gnt      = g;
  endtask

  // PC register (loads every cycle) and in-order memory with memLat cycles of latency.
  initial begin : memAndPc
    logic [31:0] pcn, gaddr, paddr;
    logic        g, clr, rvSeen, pend;
    int          cnt, lat;
    pc = '0; rvalid = 1'b0; rdata = '0; pend = 1'b0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk);
      clr    = rst;
      pcn    = rst ? 32'h0 : pcNext;
      g      = !rst && req && gnt;
      gaddr  = addr;
      rvSeen = rvalid;
      lat    = memLat;
      @(posedge clk);
      #1;
      pc = pcn;
      if (clr || rvSeen) pend = 1'b0;
      if (g) begin
        pend  = 1'b1;
        paddr = gaddr;
        cnt   = lat;
      end
      rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rvalid = 1'b1;
          rdata  = rdataOf(paddr);
        end
      end
    end
  end

  // Reference: tracks the outstanding fetch, whether it is stale, a parked response,
  // and the IF/ID contents; a request is due whenever nothing is in flight or parked.
  initial begin : model
    logic        dead, outst, disc, skv, iv, expReq, ld;
    logic [31:0] outPc, skd, ii, ipc, ipc4, expPcn, ldData;
    dead = 1'b1; outst = 1'b0; disc = 1'b0; skv = 1'b0; iv = 1'b0;
    outPc = '0; skd = '0; ii = NOP; ipc = '0; ipc4 = '0;
    forever begin
      @(negedge clk);
      expReq = !dead && !outst && !skv;
      expPcn = redirect ? target : ((expReq && gnt) ? pc + 32'd4 : pc);
      checkOutput("model req", {31'b0, req}, {31'b0, expReq});
      if (expReq) checkOutput("model addr", addr, pc);
      checkOutput("model pc_next", pcNext, expPcn);
      checkOutput("model valid", {31'b0, instrValid}, {31'b0, iv});
      checkOutput("model instr", instr, ii);
      checkOutput("model instr_pc", instrPc, ipc);
      checkOutput("model instr_pcplus4", instrPc4, ipc4);
      if (rst) begin
        dead = 1'b1; outst = 1'b0; disc = 1'b0; skv = 1'b0; iv = 1'b0;
        ii = NOP; ipc = '0; ipc4 = '0;
      end else begin
        dead = 1'b0;
        if (redirect) begin
          iv = 1'b0; ii = NOP; skv = 1'b0;
          if (expReq && gnt) begin
            outst = 1'b1; disc = 1'b1;
          end else if (outst && !rvalid) disc = 1'b1;
          else if (outst && rvalid) outst = 1'b0;
        end else begin
          ld = 1'b0; ldData = '0;
          if (expReq && gnt) begin
            outst = 1'b1; disc = 1'b0; outPc = pc;
          end else if (outst && rvalid) begin
            outst = 1'b0;
            if (!disc) begin
              if (!iv || !stall) begin
                ld = 1'b1; ldData = rdata;
              end else begin
                skv = 1'b1; skd = rdata;
              end
            end
            disc = 1'b0;
          end else if (skv && !stall) begin
            ld = 1'b1; ldData = skd; skv = 1'b0;
          end
          if (ld) begin
            iv = 1'b1; ii = ldData; ipc = outPc; ipc4 = outPc + 32'd4;
          end else if (!stall) iv = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0]  tReq, tValid;
    logic [31:0] tAddr [8];
    logic [31:0] tPc [8];
    logic [39:0] stallPat, gntPat, redirPat;
    tReq   = 8'b1010_1010;
    tValid = 8'b1010_1000;
    tAddr  = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};
    tPc    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
    stallPat = 40'h00_F0C3_3C18;
    gntPat   = 40'hFF_DF7B_EFBD;
    redirPat = 40'h00_0400_0020;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nextCycle();
    nextCycle();
    rst = 1'b0;

    // Reset release: dead cycle, then REQ/WAIT alternation at addresses 0,4,8,12.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("t1 req", {31'b0, req}, {31'b0, tReq[c]});
      if (tReq[c]) checkOutput("t1 addr", addr, tAddr[c]);
      checkOutput("t1 valid", {31'b0, instrValid}, {31'b0, tValid[c]});
      if (tValid[c]) checkOutput("t1 instr_pc", instrPc, tPc[c]);
    end
    checkOutput("t1 instr", instr, rdataOf(32'h8));

    // Stall with IF/ID valid while the response for 16 lands in the skid buffer.
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("t2 held valid", {31'b0, instrValid}, 32'd1);
    checkOutput("t2 held pc", instrPc, 32'hC);
    checkOutput("t2 no req", {31'b0, req}, 32'd0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nextCycle();
    memLat = 2;
    @(negedge clk);
    checkOutput("t2 released pc", instrPc, 32'h10);
    checkOutput("t2 released instr", instr, rdataOf(32'h10));
    checkOutput("t2 next addr", addr, 32'h14);

    // Redirect in WAIT with the response one cycle later.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    @(negedge clk);
    checkOutput("t3 pc_next", pcNext, 32'h100);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t3 drain req", {31'b0, req}, 32'd0);
    checkOutput("t3 drain valid", {31'b0, instrValid}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t3 target addr", addr, 32'h100);
    checkOutput("t3 target req", {31'b0, req}, 32'd1);
    nextCycle();
    memLat = 1;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("t3 target valid", {31'b0, instrValid}, 32'd1);
    checkOutput("t3 target pc", instrPc, 32'h100);

    // Redirect coincident with rvalid: no drain cycle.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    @(negedge clk);
    checkOutput("t4 pc_next", pcNext, 32'h100);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t4 immediate req", {31'b0, req}, 32'd1);
    checkOutput("t4 addr", addr, 32'h100);
    nextCycle();
    nextCycle();

    // Grant withheld for five cycles.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5 req", {31'b0, req}, 32'd1);
      checkOutput("t5 addr", addr, 32'h104);
      checkOutput("t5 pc_next", pcNext, 32'h104);
      if (i > 0) checkOutput("t5 valid", {31'b0, instrValid}, 32'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nextCycle();

    // Redirect to the top of the address space during a granted request, then wrap.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    checkOutput("t6 pc_next", pcNext, 32'hFFFF_FFFC);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t6 drain req", {31'b0, req}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t6 addr", addr, 32'hFFFF_FFFC);
    checkOutput("t6 wrap pc_next", pcNext, 32'h0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("t6 instr_pc", instrPc, 32'hFFFF_FFFC);
    checkOutput("t6 pcplus4 wrap", instrPc4, 32'h0);

    // Reset while a response is in flight.
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t7 valid", {31'b0, instrValid}, 32'd0);
    checkOutput("t7 instr", instr, NOP);
    checkOutput("t7 req", {31'b0, req}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t7 restart addr", addr, 32'h0);

    // Mixed stall, grant and redirect traffic, checked by the reference every cycle.
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      applyStimulus(stallPat[i], redirPat[i], 32'h200 + 32'(i) * 32'd16, gntPat[i]);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
